// File: rtl/led_code_player.sv
// LED code player: buffers 8-bit codes in a small FIFO and shows each one on
// the LEDs for HOLD_CYCLES clocks, followed by GAP_CYCLES blank clocks.
module led_code_player #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int CNT_W       = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [7:0]               led,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_led;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic [7:0]       r_mem [DEPTH];

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_cnt_zero;
  logic             w_has_data;
  logic [7:0]       w_head;

  // Ready comes only from the registered level; a same-edge pop never frees a slot early.
  assign w_ready    = (r_level != FULL_LVL);
  assign w_push     = code_valid && w_ready;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_has_data = (r_level != '0);
  assign w_head     = r_mem[r_rd_ptr];

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = w_has_data;
      S_SHOW:  w_pop = w_cnt_zero && !HAS_GAP && w_has_data;
      S_GAP:   w_pop = w_cnt_zero && w_has_data;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= code_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Dwell sequencer; w_pop is asserted exactly on the edges that enter SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_led   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_SHOW;
            r_led   <= w_head;
            r_cnt   <= HOLD_LD;
          end
        end
        S_SHOW: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (HAS_GAP) begin
            r_state <= S_GAP;
            r_led   <= '0;
            r_cnt   <= GAP_LD;
          end else if (w_pop) begin
            r_led   <= w_head;
            r_cnt   <= HOLD_LD;
          end else begin
            r_state <= S_IDLE;
            r_led   <= '0;
          end
        end
        S_GAP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_pop) begin
            r_state <= S_SHOW;
            r_led   <= w_head;
            r_cnt   <= HOLD_LD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_led   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign code_ready = w_ready;
  assign led        = r_led;
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_level;

endmodule
